ghost_target_sched: RTL
=======================

// Module: ghost_target_sched
// PURPOSE
// Generalised ghost target generator with its own mode scheduler. It runs the
// scatter/chase wave timer and the frightened timer, and computes one target
// per ghost each frame. Ghosts are processed time-multiplexed, one per clock.
// It sits between the Pac-Man position tracker and the per-ghost movement
// controllers, and replaces the per-ghost fixed-mode target generators.
// PARAMETERS
// NUM_GHOSTS     4     number of ghost channels (1..8)
// COORD_W        11    coordinate width, bits
// SCREEN_W       640   playfield width, pixels
// SCREEN_H       480   playfield height, pixels
// OFFSET_STEP    4     chase look-ahead per ghost index, pixels
// SCATTER_FRAMES 420   scatter phase length, frames
// CHASE_FRAMES   1200  chase phase length, frames
// FRIGHT_FRAMES  360   frightened length, frames
// NUM_WAVES      4     scatter phases before permanent chase
// PORTS
// clk            in   1                    system clock
// reset          in   1                    synchronous, active-high reset
// frame_tick     in   1                    one-cycle pulse, once per frame
// level_start    in   1                    pulse: restart at wave 0 scatter
// power_pellet   in   1                    pulse: enter or restart frightened
// pm_x, pm_y     in   COORD_W              Pac-Man top-left, unsigned
// pm_dir         in   2                    0 up, 1 right, 2 down, 3 left
// dev_mode       in   1                    force all targets to 0, freeze timers
// game_mode      out  2                    CHASE/SCATTER/FRIGHTENED encoding
// target_x       out  NUM_GHOSTS*COORD_W   packed, ghost g at [g*COORD_W +: COORD_W]
// target_y       out  NUM_GHOSTS*COORD_W   packed, same layout
// targets_valid  out  1                    pulse: full target set updated
// reverse        out  1                    pulse: ghosts must reverse direction
// fright_flash   out  1                    high in the last FRIGHT_FRAMES/4 frightened frames
// BEHAVIOUR
// - One clock, clk. Reset is synchronous, active-high.
// - Reset values: game_mode = SCATTER, all targets 0, targets_valid = 0,
//   reverse = 0, fright_flash = 0, FSM = IDLE, wave = 0, LFSR = 16'hACE1.
// - FSM states IDLE, SCATTER, CHASE, FRIGHT. IDLE drives SCATTER on game_mode.
//   - level_start (any state) -> SCATTER, wave = 0, phase timer = SCATTER_FRAMES.
//     level_start beats power_pellet in the same cycle.
//   - SCATTER: timer hits 0 on frame_tick -> CHASE, timer = CHASE_FRAMES.
//   - CHASE: timer hits 0 and wave < NUM_WAVES-1 -> wave++, SCATTER.
//     When wave == NUM_WAVES-1, stay in CHASE with the timer frozen.
//   - power_pellet in SCATTER or CHASE -> FRIGHT. Save the previous mode; the
//     phase timer pauses. Fright timer = FRIGHT_FRAMES.
//   - power_pellet in FRIGHT -> reload the fright timer only. No reverse.
//   - FRIGHT: fright timer hits 0 -> return to the saved mode and resume the
//     paused timer.
//   - power_pellet in IDLE is ignored.
// - Timers decrement only on frame_tick and only when dev_mode = 0.
// - reverse: one-cycle pulse, the cycle after any SCATTER<->CHASE transition
//   or FRIGHT entry. It is not pulsed on FRIGHT exit.
// - Target pipeline:
//   - frame_tick while idle: capture pm_x, pm_y, pm_dir and game_mode, and
//     step the LFSR once.
//   - Then compute ghost k in cycle k+1, k = 0..NUM_GHOSTS-1.
//   - targets_valid pulses in cycle NUM_GHOSTS+1 after the tick.
//   - A frame_tick that arrives while the pipeline is busy is ignored for
//     targets. Timers still count it.
// - Target rules for ghost g:
//   - CHASE: pm + dir_vec(pm_dir) * g * OFFSET_STEP. Compute signed at
//     COORD_W+2 bits, then clamp to [0, SCREEN_W-1] / [0, SCREEN_H-1].
//   - SCATTER: corner c = g mod 4. x = c[0] ? SCREEN_W-1 : 0;
//     y = c[1] ? SCREEN_H-1 : 0.
//   - FRIGHT: corner from LFSR bits [(2g+1)%16 : (2g)%16]; same corner map.
//   - dev_mode: target 0,0.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11.
// - Targets hold between updates.
// - Reset mid-pipeline aborts the pipeline; no targets_valid pulse.
// STRUCTURE
// - Shared package pacman_pkg: mode_t enum (CHASE, SCATTER, FRIGHTENED),
//   dir_t enum, screen constants, corner-to-xy function.
// - Sub-module ghost_mode_fsm: states, wave and phase/fright timers,
//   game_mode, reverse, fright_flash.
// - Top level holds the LFSR, the capture registers, the ghost index counter,
//   the clamp arithmetic and the target register array.
// TESTING
// - Reset, level_start, 420 frame_ticks -> game_mode CHASE after tick 420;
//   reverse pulses once.
// - pm = (100,50), dir right, CHASE, NUM_GHOSTS = 4 -> targets (100,50),
//   (104,50), (108,50), (112,50); targets_valid exactly 5 cycles after the tick.
// - pm = (638,0), dir right -> ghost 3 x clamps to 639.
//   Dir up -> ghost 3 y clamps to 0.
// - power_pellet at chase frame 100 -> FRIGHT for 360 ticks; fright_flash from
//   fright frame 270. Then CHASE resumes with 1100 frames left.
// - Second power_pellet at fright frame 200 -> fright extends to 560 total;
//   no second reverse.
// - Run through 4 waves -> CHASE persists for 5000 extra ticks; level_start
//   the same cycle as power_pellet -> SCATTER, wave 0.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and helpers for the ghost target scheduler: game modes,
// directions, scheduler states, screen defaults, corner mapping and LFSR step.
package pacman_pkg;

   typedef enum logic [1:0] {
      CHASE      = 2'd0,
      SCATTER    = 2'd1,
      FRIGHTENED = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCATTER,
      ST_CHASE,
      ST_FRIGHT
   } fsm_state_t;

   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;
   localparam int TIMER_W      = 16;
   localparam int WAVE_W       = 4;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // A set corner bit selects the far edge of that axis.
   function automatic int corner_coord(input logic far_edge, input int span);
      return far_edge ? (span - 1) : 0;
   endfunction

   // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

endpackage

// File: rtl/ghost_mode_fsm.sv
// Scatter/chase wave scheduler with a frightened overlay; the phase timer
// pauses while frightened and resumes on exit.
module ghost_mode_fsm
   import pacman_pkg::*;
#(
   parameter int SCATTER_FRAMES = 420,
   parameter int CHASE_FRAMES   = 1200,
   parameter int FRIGHT_FRAMES  = 360,
   parameter int NUM_WAVES      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       level_start,
   input  logic       power_pellet,
   input  logic       dev_mode,
   output logic [1:0] game_mode,
   output logic       reverse,
   output logic       fright_flash
);

   fsm_state_t         state_reg, state_next;
   fsm_state_t         saved_reg, saved_next;
   logic [WAVE_W-1:0]  wave_reg, wave_next;
   logic [TIMER_W-1:0] phase_reg, phase_next;
   logic [TIMER_W-1:0] fright_reg, fright_next;
   logic               reverse_reg, reverse_next;
   logic               tick;
   logic               last_wave;
   mode_t              mode;

   assign tick      = frame_tick && !dev_mode;
   assign last_wave = (wave_reg == WAVE_W'(NUM_WAVES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         saved_reg   <= ST_SCATTER;
         wave_reg    <= '0;
         phase_reg   <= '0;
         fright_reg  <= '0;
         reverse_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         saved_reg   <= saved_next;
         wave_reg    <= wave_next;
         phase_reg   <= phase_next;
         fright_reg  <= fright_next;
         reverse_reg <= reverse_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      saved_next   = saved_reg;
      wave_next    = wave_reg;
      phase_next   = phase_reg;
      fright_next  = fright_reg;
      reverse_next = 1'b0;
      if (level_start) begin
         state_next   = ST_SCATTER;
         wave_next    = '0;
         phase_next   = TIMER_W'(SCATTER_FRAMES);
         reverse_next = (state_reg == ST_CHASE);
      end else begin
         case (state_reg)
            ST_SCATTER, ST_CHASE: begin
               if (power_pellet) begin
                  saved_next   = state_reg;
                  state_next   = ST_FRIGHT;
                  fright_next  = TIMER_W'(FRIGHT_FRAMES);
                  reverse_next = 1'b1;
               end else if (tick && !(state_reg == ST_CHASE && last_wave)) begin
                  // The final chase wave never expires: its timer stays frozen.
                  if (phase_reg <= TIMER_W'(1)) begin
                     reverse_next = 1'b1;
                     if (state_reg == ST_SCATTER) begin
                        state_next = ST_CHASE;
                        phase_next = TIMER_W'(CHASE_FRAMES);
                     end else begin
                        state_next = ST_SCATTER;
                        wave_next  = wave_reg + 1'b1;
                        phase_next = TIMER_W'(SCATTER_FRAMES);
                     end
                  end else begin
                     phase_next = phase_reg - 1'b1;
                  end
               end
            end
            ST_FRIGHT: begin
               if (power_pellet) begin
                  fright_next = TIMER_W'(FRIGHT_FRAMES);
               end else if (tick) begin
                  if (fright_reg <= TIMER_W'(1)) begin
                     state_next  = saved_reg;
                     fright_next = '0;
                  end else begin
                     fright_next = fright_reg - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (state_reg)
         ST_CHASE:  mode = CHASE;
         ST_FRIGHT: mode = FRIGHTENED;
         default:   mode = SCATTER;
      endcase
   end

   assign game_mode    = mode;
   assign reverse      = reverse_reg;
   assign fright_flash = (state_reg == ST_FRIGHT) && (fright_reg <= TIMER_W'(FRIGHT_FRAMES / 4));

endmodule

// File: rtl/ghost_target_sched.sv
// Per-frame ghost target generator: captures Pac-Man state on frame_tick and
// computes one ghost target per clock, then pulses targets_valid.
module ghost_target_sched
   import pacman_pkg::*;
#(
   parameter int NUM_GHOSTS     = 4,
   parameter int COORD_W        = 11,
   parameter int SCREEN_W       = DEF_SCREEN_W,
   parameter int SCREEN_H       = DEF_SCREEN_H,
   parameter int OFFSET_STEP    = 4,
   parameter int SCATTER_FRAMES = 420,
   parameter int CHASE_FRAMES   = 1200,
   parameter int FRIGHT_FRAMES  = 360,
   parameter int NUM_WAVES      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          frame_tick,
   input  logic                          level_start,
   input  logic                          power_pellet,
   input  logic [COORD_W-1:0]            pm_x,
   input  logic [COORD_W-1:0]            pm_y,
   input  logic [1:0]                    pm_dir,
   input  logic                          dev_mode,
   output logic [1:0]                    game_mode,
   output logic [NUM_GHOSTS*COORD_W-1:0] target_x,
   output logic [NUM_GHOSTS*COORD_W-1:0] target_y,
   output logic                          targets_valid,
   output logic                          reverse,
   output logic                          fright_flash
);

   localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
   localparam int SUM_W = COORD_W + 2;
   localparam logic signed [SUM_W-1:0] MAX_X = SUM_W'(SCREEN_W - 1);
   localparam logic signed [SUM_W-1:0] MAX_Y = SUM_W'(SCREEN_H - 1);

   ghost_mode_fsm #(
      .SCATTER_FRAMES(SCATTER_FRAMES),
      .CHASE_FRAMES  (CHASE_FRAMES),
      .FRIGHT_FRAMES (FRIGHT_FRAMES),
      .NUM_WAVES     (NUM_WAVES)
   ) u_fsm (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .level_start (level_start),
      .power_pellet(power_pellet),
      .dev_mode    (dev_mode),
      .game_mode   (game_mode),
      .reverse     (reverse),
      .fright_flash(fright_flash)
   );

   logic [15:0]              lfsr_reg;
   logic [COORD_W-1:0]       cap_x_reg, cap_y_reg;
   dir_t                     cap_dir_reg;
   mode_t                    cap_mode_reg;
   logic                     cap_dev_reg;
   logic                     busy_reg;
   logic [IDX_W-1:0]         idx_reg;
   logic                     valid_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_reg     <= LFSR_SEED;
         cap_x_reg    <= '0;
         cap_y_reg    <= '0;
         cap_dir_reg  <= DIR_UP;
         cap_mode_reg <= SCATTER;
         cap_dev_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         idx_reg      <= '0;
         valid_reg    <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (!busy_reg && frame_tick) begin
            lfsr_reg     <= lfsr_step(lfsr_reg);
            cap_x_reg    <= pm_x;
            cap_y_reg    <= pm_y;
            cap_dir_reg  <= dir_t'(pm_dir);
            cap_mode_reg <= mode_t'(game_mode);
            cap_dev_reg  <= dev_mode;
            busy_reg     <= 1'b1;
            idx_reg      <= '0;
         end else if (busy_reg) begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == IDX_W'(NUM_GHOSTS - 1)) begin
               busy_reg  <= 1'b0;
               valid_reg <= 1'b1;
            end
         end
      end
   end

   logic signed [SUM_W-1:0] off, base_x, base_y, sum_x, sum_y;
   logic [1:0]              corner;
   logic [COORD_W-1:0]      calc_x, calc_y;

   always_comb begin
      off    = SUM_W'(int'(idx_reg) * OFFSET_STEP);
      base_x = $signed({2'b00, cap_x_reg});
      base_y = $signed({2'b00, cap_y_reg});
      sum_x  = base_x;
      sum_y  = base_y;
      case (cap_dir_reg)
         DIR_UP:    sum_y = base_y - off;
         DIR_RIGHT: sum_x = base_x + off;
         DIR_DOWN:  sum_y = base_y + off;
         default:   sum_x = base_x - off;
      endcase
      // Frightened ghosts pick a pseudo-random corner from their own LFSR pair.
      corner = (cap_mode_reg == FRIGHTENED) ? 2'(lfsr_reg >> {idx_reg, 1'b0}) : 2'(idx_reg);
      calc_x = '0;
      calc_y = '0;
      if (!cap_dev_reg) begin
         if (cap_mode_reg == CHASE) begin
            if (sum_x < 0)          calc_x = '0;
            else if (sum_x > MAX_X) calc_x = COORD_W'(SCREEN_W - 1);
            else                    calc_x = sum_x[COORD_W-1:0];
            if (sum_y < 0)          calc_y = '0;
            else if (sum_y > MAX_Y) calc_y = COORD_W'(SCREEN_H - 1);
            else                    calc_y = sum_y[COORD_W-1:0];
         end else begin
            calc_x = COORD_W'(corner_coord(corner[0], SCREEN_W));
            calc_y = COORD_W'(corner_coord(corner[1], SCREEN_H));
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
         logic [COORD_W-1:0] tx_reg, ty_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               tx_reg <= '0;
               ty_reg <= '0;
            end else if (busy_reg && idx_reg == IDX_W'(gi)) begin
               tx_reg <= calc_x;
               ty_reg <= calc_y;
            end
         end
         assign target_x[gi*COORD_W +: COORD_W] = tx_reg;
         assign target_y[gi*COORD_W +: COORD_W] = ty_reg;
      end
   endgenerate

   assign targets_valid = valid_reg;

endmodule
